// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, state encoding and vector helper for the irq scheduler
package irq_pkg;

    localparam int NUM_IRQ = 4;
    localparam int ID_W    = $clog2(NUM_IRQ);

    localparam logic [7:0]  VEC_BASE_DEF = 8'hF0;
    localparam int unsigned TIMEOUT_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Each vector table entry is one 4-byte slot; the sum wraps at 8 bits.
    function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [ID_W-1:0] id);
        return base + {{(8 - ID_W - 2){1'b0}}, id, 2'b00};
    endfunction

endpackage

// File: rtl/irq_scheduler_if.sv
// rtl/irq_scheduler_if.sv - peripheral/config/cpu signal bundle of the irq scheduler
interface irq_scheduler_if;
    import irq_pkg::*;

    logic [NUM_IRQ-1:0] irq_req;
    logic               cfg_we;
    logic [NUM_IRQ-1:0] cfg_mask;
    logic               cpu_ack;
    logic               cpu_done;
    logic               interrupt;
    logic [7:0]         vector;
    logic [ID_W-1:0]    active_id;
    logic               busy;
    logic [NUM_IRQ-1:0] pending;
    logic               timeout_err;

    // Scheduler side.
    modport slave (
        input  irq_req, cfg_we, cfg_mask, cpu_ack, cpu_done,
        output interrupt, vector, active_id, busy, pending, timeout_err
    );

    // Peripheral / core side.
    modport master (
        output irq_req, cfg_we, cfg_mask, cpu_ack, cpu_done,
        input  interrupt, vector, active_id, busy, pending, timeout_err
    );

endinterface

// File: rtl/irq_scheduler_rr_arbiter.sv
// rtl/irq_scheduler_rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    // Scan last_grant+1 .. last_grant+NUM_IRQ (mod NUM_IRQ); the first eligible id wins.
    always_comb begin
        logic [ID_W-1:0] w_idx;
        grant_id    = last_grant;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_IRQ; k++) begin
            w_idx = last_grant + ID_W'(k);
            if (!grant_valid && eligible[w_idx]) begin
                grant_valid = 1'b1;
                grant_id    = w_idx;
            end
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - latches edge-triggered requests and grants them one at a time to the core
module irq_scheduler
    import irq_pkg::*;
#(
    parameter logic [7:0]  VEC_BASE = VEC_BASE_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    irq_scheduler_if.slave bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [7:0]         r_timer;
    logic [ID_W-1:0]    r_active_id;
    logic [ID_W-1:0]    r_last_grant;
    logic               r_timeout_err;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_clr_mask;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_grant_valid;
    logic               w_load_grant;
    logic               w_service_done;
    logic               w_timeout_hit;

    assign w_rise     = bus.irq_req & ~r_irq_q;
    assign w_eligible = r_pending & r_mask;

    rr_arbiter u_arb (
        .eligible    (w_eligible),
        .last_grant  (r_last_grant),
        .grant_id    (w_grant_id),
        .grant_valid (w_grant_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; ack takes priority over timer expiry, stray ack/done are ignored.
    always_comb begin
        w_next_state   = r_state;
        w_load_grant   = 1'b0;
        w_service_done = 1'b0;
        w_timeout_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = ASSERT;
                    w_load_grant = 1'b1;
                end
            end
            ASSERT: begin
                if (bus.cpu_ack) begin
                    w_next_state = SERVICE;
                end else if (r_timer == TMO_LAST) begin
                    w_next_state  = IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            SERVICE: begin
                if (bus.cpu_done) begin
                    w_next_state   = IDLE;
                    w_service_done = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // One-hot clear of the bit whose service just finished.
    always_comb begin
        w_clr_mask = '0;
        if (w_service_done) begin
            w_clr_mask[r_active_id] = 1'b1;
        end
    end

    // Request latching: a new rising edge beats a simultaneous clear on the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_q   <= bus.irq_req;
            r_pending <= (r_pending & ~w_clr_mask) | w_rise;
        end
    end

    // Mask register; changing it never disturbs a grant already in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (bus.cfg_we) begin
            r_mask <= bus.cfg_mask;
        end
    end

    // Ack timer counts only while staying in ASSERT, otherwise parked at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == ASSERT && w_next_state == ASSERT) begin
            r_timer <= r_timer + 8'd1;
        end else begin
            r_timer <= '0;
        end
    end

    // Grant bookkeeping: active id frozen for the whole grant, round-robin pointer moves on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active_id   <= '0;
            r_last_grant  <= ID_W'(NUM_IRQ - 1);
            r_timeout_err <= 1'b0;
        end else begin
            if (w_load_grant) begin
                r_active_id <= w_grant_id;
            end
            if (w_service_done) begin
                r_last_grant <= r_active_id;
            end
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign bus.interrupt   = (r_state == ASSERT);
    assign bus.busy        = (r_state != IDLE);
    assign bus.vector      = vec_addr(VEC_BASE, r_active_id);
    assign bus.active_id   = r_active_id;
    assign bus.pending     = r_pending;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_irq_scheduler.sv
// tb/tb_irq_scheduler.sv - directed and randomized checks of irq_scheduler against a transaction model
module tb_irq_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] m_pending;
    logic [3:0] m_mask;
    int         m_last;

    irq_scheduler_if bus ();

    irq_scheduler #(.VEC_BASE(8'hF0), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [3:0] elig, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (elig[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_vec(input int id);
        return 8'((32'hF0 + 32'(id) * 4) % 256);
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        bus.irq_req  = 4'h0;
        bus.cfg_we   = 1'b0;
        bus.cfg_mask = 4'h0;
        bus.cpu_ack  = 1'b0;
        bus.cpu_done = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
        m_pending = 4'h0;
        m_mask    = 4'h0;
        m_last    = 3;
    endtask

    task automatic write_mask(input logic [3:0] m);
        bus.cfg_we   = 1'b1;
        bus.cfg_mask = m;
        tick();
        bus.cfg_we   = 1'b0;
        m_mask       = m;
    endtask

    task automatic wait_int(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.interrupt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_interrupt got %b exp 0", bus.interrupt); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.vector !== 8'hF0) begin n_fail++; $display("FAIL reset_vector got %h exp f0", bus.vector); end
        n_tests++; if (bus.active_id !== 2'd0) begin n_fail++; $display("FAIL reset_active_id got %0d exp 0", bus.active_id); end
        n_tests++; if (bus.pending !== 4'h0) begin n_fail++; $display("FAIL reset_pending got %b exp 0000", bus.pending); end
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got %b exp 0", bus.timeout_err); end
        bus.irq_req = 4'b0001;
        tick();
        tick();
        tick();
        n_tests++; if (bus.pending !== 4'b0001) begin n_fail++; $display("FAIL reset_mask_pending got %b exp 0001", bus.pending); end
        n_tests++; if (bus.interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_mask_blocks got %b exp 0", bus.interrupt); end
    endtask

    task automatic test_single();
        do_reset();
        write_mask(4'hF);
        bus.irq_req = 4'b0100;
        tick();
        n_tests++; if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending got %b exp 0100", bus.pending); end
        n_tests++; if (bus.interrupt !== 1'b0) begin n_fail++; $display("FAIL single_latency1 got %b exp 0", bus.interrupt); end
        tick();
        n_tests++; if (bus.interrupt !== 1'b1) begin n_fail++; $display("FAIL single_latency2 got %b exp 1", bus.interrupt); end
        n_tests++; if (bus.vector !== 8'hF8) begin n_fail++; $display("FAIL single_vector got %h exp f8", bus.vector); end
        n_tests++; if (bus.active_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d exp 2", bus.active_id); end
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        n_tests++; if (bus.interrupt !== 1'b1) begin n_fail++; $display("FAIL single_done_in_assert got %b exp 1", bus.interrupt); end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++; if (bus.interrupt !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_service got int=%b busy=%b exp int=0 busy=1", bus.interrupt, bus.busy); end
        n_tests++; if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending_service got %b exp 0100", bus.pending); end
        bus.irq_req  = 4'b0000;
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        n_tests++; if (bus.pending !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_done got pending=%b busy=%b exp 0000 0", bus.pending, bus.busy); end
        bus.cpu_ack  = 1'b1;
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_ack  = 1'b0;
        bus.cpu_done = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_stray_pulses got busy=%b exp 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int exp_ids[4] = '{0, 3, 0, 3};
        bit ok;
        do_reset();
        write_mask(4'hF);
        for (int r = 0; r < 2; r++) begin
            bus.irq_req = 4'b1001;
            tick();
            bus.irq_req = 4'b0000;
            for (int g = 0; g < 2; g++) begin
                wait_int(ok);
                n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_wait round %0d grant %0d got no interrupt exp interrupt", r, g); end
                n_tests++; if (int'(bus.active_id) != exp_ids[r*2+g]) begin n_fail++; $display("FAIL rr_order round %0d grant %0d got %0d exp %0d", r, g, bus.active_id, exp_ids[r*2+g]); end
                bus.cpu_ack = 1'b1;
                tick();
                bus.cpu_ack  = 1'b0;
                bus.cpu_done = 1'b1;
                tick();
                bus.cpu_done = 1'b0;
                n_tests++; if (bus.interrupt !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_gap got int=%b busy=%b exp 0 0", bus.interrupt, bus.busy); end
                if (g == 0) begin
                    tick();
                    n_tests++; if (bus.interrupt !== 1'b1) begin n_fail++; $display("FAIL rr_regrant got %b exp 1", bus.interrupt); end
                end
            end
        end
    endtask

    task automatic test_mask();
        do_reset();
        bus.irq_req = 4'b0010;
        tick();
        bus.irq_req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if (bus.pending !== 4'b0010 || bus.interrupt !== 1'b0) begin n_fail++; $display("FAIL mask_latched got pending=%b int=%b exp 0010 0", bus.pending, bus.interrupt); end
        bus.cfg_we   = 1'b1;
        bus.cfg_mask = 4'h2;
        tick();
        bus.cfg_we   = 1'b0;
        n_tests++; if (bus.interrupt !== 1'b0) begin n_fail++; $display("FAIL mask_latency1 got %b exp 0", bus.interrupt); end
        tick();
        n_tests++; if (bus.interrupt !== 1'b1 || bus.vector !== 8'hF4) begin n_fail++; $display("FAIL mask_grant got int=%b vec=%h exp 1 f4", bus.interrupt, bus.vector); end
        bus.cfg_we   = 1'b1;
        bus.cfg_mask = 4'h0;
        tick();
        bus.cfg_we = 1'b0;
        tick();
        n_tests++; if (bus.interrupt !== 1'b1 || bus.active_id !== 2'd1) begin n_fail++; $display("FAIL mask_no_abort got int=%b id=%0d exp 1 1", bus.interrupt, bus.active_id); end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack  = 1'b0;
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        n_tests++; if (bus.pending !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mask_done got pending=%b busy=%b exp 0000 0", bus.pending, bus.busy); end
    endtask

    task automatic test_timeout();
        int  high;
        bit  vec_ok;
        do_reset();
        write_mask(4'hF);
        bus.irq_req = 4'b0010;
        tick();
        bus.irq_req = 4'b0000;
        tick();
        high   = 0;
        vec_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.interrupt === 1'b1) begin
                high++;
                if (bus.vector !== 8'hF4) vec_ok = 1'b0;
            end else if (high > 0) begin
                break;
            end
            tick();
        end
        n_tests++; if (high != 16) begin n_fail++; $display("FAIL timeout_high_cycles got %0d exp 16", high); end
        n_tests++; if (!vec_ok) begin n_fail++; $display("FAIL timeout_vector_stable got unstable exp f4"); end
        n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b exp 1", bus.timeout_err); end
        n_tests++; if (bus.pending !== 4'b0010) begin n_fail++; $display("FAIL timeout_pending got %b exp 0010", bus.pending); end
        tick();
        n_tests++; if (bus.interrupt !== 1'b1) begin n_fail++; $display("FAIL timeout_retry got %b exp 1", bus.interrupt); end
        for (int i = 0; i < 15; i++) tick();
        n_tests++; if (bus.interrupt !== 1'b1) begin n_fail++; $display("FAIL timeout_last_cycle got %b exp 1", bus.interrupt); end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++; if (bus.busy !== 1'b1 || bus.interrupt !== 1'b0) begin n_fail++; $display("FAIL timeout_ack_wins got busy=%b int=%b exp 1 0", bus.busy, bus.interrupt); end
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        n_tests++; if (bus.pending !== 4'b0000 || bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got pending=%b err=%b exp 0000 1", bus.pending, bus.timeout_err); end
    endtask

    task automatic test_collision();
        bit ok;
        do_reset();
        write_mask(4'hF);
        bus.irq_req = 4'b0010;
        tick();
        wait_int(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL collision_wait got no interrupt exp interrupt"); end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        bus.irq_req = 4'b0000;
        tick();
        bus.irq_req  = 4'b0010;
        bus.cpu_done = 1'b1;
        tick();
        bus.cpu_done = 1'b0;
        n_tests++; if (bus.pending !== 4'b0010 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL collision_set_wins got pending=%b busy=%b exp 0010 0", bus.pending, bus.busy); end
        tick();
        n_tests++; if (bus.interrupt !== 1'b1 || bus.active_id !== 2'd1) begin n_fail++; $display("FAIL collision_regrant got int=%b id=%0d exp 1 1", bus.interrupt, bus.active_id); end
    endtask

    task automatic test_reset_service();
        bit ok;
        do_reset();
        write_mask(4'hF);
        bus.irq_req = 4'b0001;
        tick();
        wait_int(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_svc_wait got no interrupt exp interrupt"); end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (bus.interrupt !== 1'b0 || bus.busy !== 1'b0 || bus.pending !== 4'h0) begin n_fail++; $display("FAIL rst_svc_clear got int=%b busy=%b pending=%b exp 0 0 0000", bus.interrupt, bus.busy, bus.pending); end
        tick();
        tick();
        tick();
        n_tests++; if (bus.pending !== 4'b0001 || bus.interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_svc_mask_zero got pending=%b int=%b exp 0001 0", bus.pending, bus.interrupt); end
        bus.irq_req = 4'b0000;
    endtask

    task automatic serve_model(input int rnd);
        bit ok;
        int exp_id;
        for (int n = 0; n < 4 && (m_pending & m_mask) != 4'h0; n++) begin
            exp_id = model_pick(m_pending & m_mask, m_last);
            wait_int(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_wait round %0d got no interrupt exp interrupt", rnd); end
            n_tests++; if (int'(bus.active_id) != exp_id || bus.vector !== model_vec(exp_id)) begin n_fail++; $display("FAIL rand_grant round %0d got id=%0d vec=%h exp id=%0d vec=%h", rnd, bus.active_id, bus.vector, exp_id, model_vec(exp_id)); end
            bus.cpu_ack = 1'b1;
            tick();
            bus.cpu_ack  = 1'b0;
            bus.cpu_done = 1'b1;
            tick();
            bus.cpu_done = 1'b0;
            m_pending[exp_id] = 1'b0;
            m_last            = exp_id;
            n_tests++; if (bus.pending !== m_pending) begin n_fail++; $display("FAIL rand_pending round %0d got %b exp %b", rnd, bus.pending, m_pending); end
        end
    endtask

    task automatic test_random();
        logic [3:0] bits;
        do_reset();
        for (int r = 0; r < 20; r++) begin
            write_mask(4'($urandom_range(0, 15)));
            serve_model(r);
            bits        = 4'($urandom_range(0, 15));
            bus.irq_req = bits;
            m_pending   = m_pending | bits;
            tick();
            bus.irq_req = 4'h0;
            tick();
            serve_model(r);
            tick();
            n_tests++; if (bus.interrupt !== 1'b0 || bus.pending !== m_pending) begin n_fail++; $display("FAIL rand_idle round %0d got int=%b pending=%b exp 0 %b", r, bus.interrupt, bus.pending, m_pending); end
        end
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rand_no_timeout got %b exp 0", bus.timeout_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_timeout();
        test_collision();
        test_reset_service();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_scheduler.md
IRQ_SCHEDULER -- requirements
Module: irq_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  VEC_BASE  8'hF0  base instruction address of the 4-entry ISR vector table
  TIMEOUT   16     cycles to wait in ASSERT for cpu_ack before abandoning the grant (legal range 2..255)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk          in   1  single clock; all state updates on its rising edge
  reset        in   1  synchronous, active-high reset
  irq_req      in   4  level requests from peripherals; a rising edge raises a request
  cfg_we       in   1  write strobe for the mask register
  cfg_mask     in   4  new mask value (1 = enabled), captured when cfg_we=1
  cpu_ack      in   1  one-cycle pulse: core has taken the interrupt and loaded the vector
  cpu_done     in   1  one-cycle pulse: core executed return-from-interrupt
  interrupt    out  1  drives the processor interrupt input
  vector       out  8  ISR address = VEC_BASE + {active_id, 2'b00}, 8-bit wrap
  active_id    out  2  index of the granted source
  busy         out  1  high in ASSERT and SERVICE
  pending      out  4  latched-request register
  timeout_err  out  1  sticky flag; set on an ack timeout
REQ-003 Clock and reset SHALL be one clock, clk, with reset synchronous and active-high.

Function
REQ-004 Edge detection SHALL use a registered copy of irq_req; bit i of pending SHALL set after any edge where irq_req[i]=1 and its registered copy is 0.
REQ-005 pending[i] SHALL clear only on the cpu_done that ends service of id i; if a clear and a new edge on the same bit coincide, the set SHALL win.
REQ-006 Eligibility SHALL be pending & mask; masked bits SHALL stay latched and become eligible when unmasked.
REQ-007 The FSM SHALL have three states: IDLE, ASSERT, SERVICE.
REQ-008 IDLE with any eligible bit: at the next edge the block SHALL enter ASSERT, and active_id SHALL load the round-robin winner.
  - Round-robin search order SHALL be last_grant+1, last_grant+2, ... mod 4.
REQ-009 ASSERT: interrupt SHALL be 1 and the timer SHALL increment each cycle.
  - On cpu_ack the block SHALL enter SERVICE.
  - If the timer reaches TIMEOUT-1 without cpu_ack, the block SHALL return to IDLE, set timeout_err, and leave pending unchanged.
REQ-010 SERVICE: interrupt SHALL be 0. On cpu_done the block SHALL clear pending[active_id], set last_grant=active_id and return to IDLE; nesting SHALL NOT occur.
REQ-011 cpu_ack outside ASSERT and cpu_done outside SERVICE SHALL be ignored; cpu_ack and timer expiry in the same cycle SHALL resolve as ack.
REQ-012 A mask write SHALL take effect the next cycle and SHALL NOT abort a grant already in ASSERT or SERVICE.
REQ-013 Latency from irq_req rising (sampled at edge k) to interrupt=1 SHALL be 2 cycles when IDLE; vector and active_id SHALL be stable whenever interrupt=1.
REQ-014 Minimum re-arbitration gap SHALL be one IDLE cycle after cpu_done.

Reset
REQ-015 When reset=1 at an edge, the following SHALL be cleared: state=IDLE, pending=0, mask=0 (all disabled), timer=0, active_id=0, timeout_err=0, irq_req registered copy=0.
  - last_grant SHALL reset to 3 so that id 0 wins first.
  - Outputs after reset: interrupt=0, busy=0, vector=VEC_BASE.
REQ-016 A reset in mid-ASSERT or mid-SERVICE SHALL abandon the grant with no cpu_done required.

Structure
REQ-017 A shared package irq_pkg SHALL hold NUM_IRQ=4, the state enum (IDLE/ASSERT/SERVICE) and default VEC_BASE/TIMEOUT constants.
REQ-018 One combinational sub-module, rr_arbiter, SHALL be instantiated: inputs eligible[3:0] and last_grant[1:0]; outputs grant_id[1:0] and grant_valid.

Verification
REQ-019 Single source: mask=4'hF; irq_req[2] rises -> interrupt=1 two cycles later with vector=8'hF8; cpu_ack -> interrupt=0; cpu_done -> pending=4'b0000.
REQ-020 Round-robin fairness: mask=4'hF; irq_req[0] and irq_req[3] rise together -> grant order 0 then 3; re-raise both -> grant order 0 then 3.
REQ-021 Mask: mask=4'h0; irq_req[1] rises -> pending=4'b0010 and interrupt stays 0; write mask=4'h2 -> interrupt=1 two cycles later with vector=8'hF4.
REQ-022 Timeout: TIMEOUT=16, no cpu_ack -> interrupt high exactly 16 cycles, then timeout_err=1 and pending bit retained; a retry is granted afterwards.
REQ-023 Collision: during SERVICE of id 1, irq_req[1] re-rises in the same cycle as cpu_done -> pending[1] stays 1 and a new grant of id 1 follows.
REQ-024 Reset in SERVICE: reset=1 for one cycle -> interrupt=0, busy=0, pending=0 and mask=0 on the next cycle.
